// File: rtl/fp_align_add_norm.sv
// rtl/fp_align_add_norm.sv - align, carry-select add and normalize two float significands
//
// Aligns sig_shift right by shift_amt, adds it to sig_fixed with a carry-select
// adder and normalizes the sum against exp_in. One registered output stage.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands valid this cycle
//   sig_shift  in   [23:0] significand to align (hidden bit at [23])
//   shift_amt  in   [7:0]  right-shift amount (exponent difference)
//   sig_fixed  in   [23:0] non-shifted significand
//   exp_in     in   [7:0]  larger biased exponent
//   out_valid  out  in_valid delayed one cycle
//   norm_sig   out  [23:0] normalized significand
//   norm_exp   out  [7:0]  normalized biased exponent
//   cout       out  raw adder carry-out
//   overflow   out  result exponent saturated at 255
//   zero       out  raw sum was zero

module fp_align_add_norm #(
   parameter int BLOCK_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [23:0] sig_shift,
   input  logic [7:0]  shift_amt,
   input  logic [23:0] sig_fixed,
   input  logic [7:0]  exp_in,
   output logic        out_valid,
   output logic [23:0] norm_sig,
   output logic [7:0]  norm_exp,
   output logic        cout,
   output logic        overflow,
   output logic        zero
);

   localparam int NB = 24 / BLOCK_W;

   // Leading-zero count of a 24-bit value; an all-zero value reports 24.
   function automatic logic [4:0] lzc(input logic [23:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd24;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(23 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   // ---------------------------------------------------------------- align
   // Shifts of 24 or more clear every bit; shifted-out bits are dropped.
   logic [23:0] shifted;
   assign shifted = (shift_amt >= 8'd24) ? 24'd0 : (sig_shift >> shift_amt);

   // ----------------------------------------------------- carry-select add
   logic [NB:0] carry;
   logic [23:0] sum;
   logic        cout_raw;

   assign carry[0] = 1'b0;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BLOCK_W:0] s0;
      logic [BLOCK_W:0] s1;
      // Both candidate sums are formed in parallel; the incoming carry only picks one.
      assign s0 = {1'b0, sig_fixed[g*BLOCK_W +: BLOCK_W]}
                + {1'b0, shifted[g*BLOCK_W +: BLOCK_W]};
      assign s1 = {1'b0, sig_fixed[g*BLOCK_W +: BLOCK_W]}
                + {1'b0, shifted[g*BLOCK_W +: BLOCK_W]}
                + {{BLOCK_W{1'b0}}, 1'b1};
      assign sum[g*BLOCK_W +: BLOCK_W] = carry[g] ? s1[BLOCK_W-1:0] : s0[BLOCK_W-1:0];
      assign carry[g+1]                = carry[g] ? s1[BLOCK_W]     : s0[BLOCK_W];
   end

   assign cout_raw = carry[NB];

   // ------------------------------------------------------------ normalize
   logic [4:0]  lz;
   logic [8:0]  exp_inc;
   logic [23:0] n_sig;
   logic [7:0]  n_exp;
   logic        n_ovf;
   logic        n_zero;

   assign lz      = lzc(sum);
   assign exp_inc = {1'b0, exp_in} + 9'd1;

   always_comb begin
      n_sig  = 24'd0;
      n_exp  = 8'd0;
      n_ovf  = 1'b0;
      n_zero = 1'b0;
      if (cout_raw) begin
         if (exp_inc >= 9'd255) begin
            n_exp = 8'd255;
            n_ovf = 1'b1;
         end else begin
            n_sig = {1'b1, sum[23:1]};
            n_exp = exp_inc[7:0];
         end
      end else if (sum == 24'd0) begin
         n_zero = 1'b1;
      end else if (sum[23]) begin
         n_sig = sum;
         n_exp = exp_in;
      end else if ({3'b000, lz} < exp_in) begin
         n_sig = sum << lz;
         n_exp = exp_in - {3'b000, lz};
      end else begin
         // Exponent cannot absorb the full left shift: emit a denormal,
         // shifting only as far as exponent 1 allows.
         n_exp = 8'd0;
         if (exp_in != 8'd0) begin
            n_sig = sum << (exp_in - 8'd1);
         end else begin
            n_sig = sum;
         end
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         norm_sig  <= 24'd0;
         norm_exp  <= 8'd0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            norm_sig <= n_sig;
            norm_exp <= n_exp;
            cout     <= cout_raw;
            overflow <= n_ovf;
            zero     <= n_zero;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_add_norm.sv
// tb/tb_fp_align_add_norm.sv - randomized self-checking bench for fp_align_add_norm

module tb_fp_align_add_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] sig_shift;
   logic [7:0]  shift_amt;
   logic [23:0] sig_fixed;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic [23:0] norm_sig;
   logic [7:0]  norm_exp;
   logic        cout;
   logic        overflow;
   logic        zero;

   int tests  = 0;
   int failed = 0;

   // Last expected result, used to check hold behaviour.
   int h_sig, h_exp, h_c, h_ovf, h_zero;

   fp_align_add_norm #(.BLOCK_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .sig_shift (sig_shift),
      .shift_amt (shift_amt),
      .sig_fixed (sig_fixed),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .norm_sig  (norm_sig),
      .norm_exp  (norm_exp),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: straight integer arithmetic following the rules for align, add, normalize.
   task automatic model(input int ss, input int amt, input int fx, input int ex,
                        output int es, output int ee, output int ec,
                        output int eo, output int ez);
      int sh, s, sm, lz;
      sh = (amt >= 24) ? 0 : (ss >> amt);
      s  = fx + sh;
      ec = (s >> 24) & 1;
      sm = s & 32'hFFFFFF;
      es = 0; ee = 0; eo = 0; ez = 0;
      if (ec == 1) begin
         if (ex + 1 >= 255) begin
            ee = 255; es = 0; eo = 1;
         end else begin
            es = 32'h800000 | (sm >> 1);
            ee = ex + 1;
         end
      end else if (sm == 0) begin
         ez = 1;
      end else if (sm >= 32'h800000) begin
         es = sm; ee = ex;
      end else begin
         lz = 0;
         while (((sm << lz) & 32'h800000) == 0) lz++;
         if (lz < ex) begin
            es = (sm << lz) & 32'hFFFFFF;
            ee = ex - lz;
         end else begin
            ee = 0;
            es = (ex >= 1) ? ((sm << (ex - 1)) & 32'hFFFFFF) : sm;
         end
      end
   endtask

   // Called at a negedge: drives one valid operand set, then checks at the next negedge.
   task automatic run_op(input string tag, input int ss, input int amt, input int fx, input int ex);
      int es, ee, ec, eo, ez;
      sig_shift = ss[23:0];
      shift_amt = amt[7:0];
      sig_fixed = fx[23:0];
      exp_in    = ex[7:0];
      in_valid  = 1'b1;
      model(ss, amt, fx, ex, es, ee, ec, eo, ez);
      @(negedge clk);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".sig"},   32'(norm_sig),  es);
      check({tag, ".exp"},   32'(norm_exp),  ee);
      check({tag, ".cout"},  32'(cout),      ec);
      check({tag, ".ovf"},   32'(overflow),  eo);
      check({tag, ".zero"},  32'(zero),      ez);
      h_sig = es; h_exp = ee; h_c = ec; h_ovf = eo; h_zero = ez;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".sig"},   32'(norm_sig),  32'd0);
      check({tag, ".exp"},   32'(norm_exp),  32'd0);
      check({tag, ".cout"},  32'(cout),      32'd0);
      check({tag, ".ovf"},   32'(overflow),  32'd0);
      check({tag, ".zero"},  32'(zero),      32'd0);
   endtask

   initial begin
      int ss, amt, fx, ex;
      rst       = 1'b1;
      in_valid  = 1'b0;
      sig_shift = 24'd0;
      shift_amt = 8'd0;
      sig_fixed = 24'd0;
      exp_in    = 8'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      run_op("align_add",   32'h800000, 1,  32'h800000, 127);
      check("align_add.sig_lit", 32'(norm_sig), 32'hC00000);
      run_op("carry_norm",  32'h800000, 0,  32'h800000, 127);
      check("carry_norm.exp_lit", 32'(norm_exp), 32'd128);
      run_op("large_shift", 32'hFFFFFF, 30, 32'h900000, 100);
      run_op("left_norm",   32'h000000, 24, 32'h000100, 127);
      check("left_norm.exp_lit", 32'(norm_exp), 32'd112);
      run_op("denorm",      32'h000000, 24, 32'h000100, 5);
      check("denorm.sig_lit", 32'(norm_sig), 32'h001000);
      run_op("denorm_e0",   32'h000000, 24, 32'h000100, 0);
      run_op("overflow",    32'hFFFFFF, 0,  32'hFFFFFF, 254);
      check("overflow.exp_lit", 32'(norm_exp), 32'd255);
      run_op("carry_253",   32'hFFFFFF, 0,  32'hFFFFFF, 253);
      run_op("zero",        32'h000000, 0,  32'h000000, 50);
      run_op("shift_23",    32'hFFFFFF, 23, 32'h7FFFFF, 10);
      run_op("lz_eq_exp",   32'h000000, 24, 32'h000100, 15);
      run_op("lz_exp_16",   32'h000000, 24, 32'h000100, 16);

      // Hold when in_valid is low
      in_valid  = 1'b0;
      sig_shift = 24'h123456;
      sig_fixed = 24'h654321;
      exp_in    = 8'd77;
      shift_amt = 8'd3;
      @(negedge clk);
      check("hold.valid", 32'(out_valid), 32'd0);
      check("hold.sig",   32'(norm_sig),  h_sig);
      check("hold.exp",   32'(norm_exp),  h_exp);
      check("hold.cout",  32'(cout),      h_c);
      check("hold.zero",  32'(zero),      h_zero);
      @(negedge clk);

      // Randomized back-to-back stream
      for (int i = 0; i < 400; i++) begin
         ss  = int'($urandom & 32'hFFFFFF);
         if ($urandom_range(0, 1) == 1) ss = ss | 32'h800000;
         fx  = int'($urandom & 32'hFFFFFF);
         if ($urandom_range(0, 3) == 0) fx = fx >> $urandom_range(0, 23);
         amt = int'($urandom_range(0, 40));
         case ($urandom_range(0, 3))
            0:       ex = int'($urandom_range(0, 24));
            1:       ex = int'($urandom_range(250, 255));
            default: ex = int'($urandom_range(0, 255));
         endcase
         run_op($sformatf("rand%0d", i), ss, amt, fx, ex);
      end

      // Asynchronous reset between edges, with a valid operand in flight
      sig_shift = 24'h800000;
      shift_amt = 8'd0;
      sig_fixed = 24'h800000;
      exp_in    = 8'd10;
      in_valid  = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      check_reset_outputs("rst_held");
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      check("post_rst.valid", 32'(out_valid), 32'd0);
      check("post_rst.sig",   32'(norm_sig),  32'd0);
      run_op("after_rst", 32'h400000, 2, 32'h800000, 60);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fp_align_add_norm.md
FP_ALIGN_ADD_NORM -- requirements
Module: fp_align_add_norm

Interface
REQ-001 SHALL have parameter BLOCK_W, default 4: carry-select block width (must divide 24).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: operands valid this cycle.
REQ-005 SHALL have port sig_shift, input, 24: significand to be aligned (hidden bit at [23]).
REQ-006 SHALL have port shift_amt, input, 8: right-shift amount (exponent difference).
REQ-007 SHALL have port sig_fixed, input, 24: non-shifted significand.
REQ-008 SHALL have port exp_in, input, 8: larger biased exponent (result exponent before normalization).
REQ-009 SHALL have port out_valid, output, 1: result registers hold the result of a valid input.
REQ-010 SHALL have port norm_sig, output, 24: normalized significand.
REQ-011 SHALL have port norm_exp, output, 8: normalized biased exponent.
REQ-012 SHALL have port cout, output, 1: raw adder carry-out.
REQ-013 SHALL have port overflow, output, 1: result exponent reached 255.
REQ-014 SHALL have port zero, output, 1: raw sum equals zero.

Function
REQ-015 Alignment SHALL compute shifted = sig_shift >> shift_amt, logical, zero-filled; shift_amt >= 24 SHALL give 0; shifted-out bits discarded (no guard/sticky).
REQ-016 Addition SHALL compute {cout_raw, sum} = sig_fixed + shifted, unsigned 25-bit result.
REQ-017 Adder SHALL be carry-select: 24/BLOCK_W blocks, each precomputing sums for carry-in 0 and 1, selected by the previous block's carry; first block carry-in 0.
REQ-018 Normalize, cout_raw=1: norm_sig = {1, sum[23:1]}, norm_exp = exp_in+1.
REQ-019 Normalize, cout_raw=1 and exp_in+1 >= 255: norm_exp = 255, norm_sig = 0, overflow = 1.
REQ-020 Normalize, cout_raw=0 and sum[23]=1: norm_sig = sum, norm_exp = exp_in.
REQ-021 Normalize, sum=0 and cout_raw=0: norm_sig = 0, norm_exp = 0, zero = 1.
REQ-022 Normalize, otherwise with lz = leading-zero count of sum and lz < exp_in: norm_sig = sum << lz, norm_exp = exp_in - lz.
REQ-023 Normalize, otherwise with lz >= exp_in: denormal result; norm_exp = 0, norm_sig = sum << (exp_in-1) if exp_in >= 1, sum unshifted if exp_in = 0.
REQ-024 overflow and zero SHALL be 0 in all cases other than REQ-019 and REQ-021.
REQ-025 Latency SHALL be 1 cycle: datapath combinational, outputs registered on the clk edge where in_valid=1.
REQ-026 out_valid SHALL equal in_valid delayed one cycle.
REQ-027 When in_valid=0, data outputs SHALL hold their previous values.
REQ-028 Back-to-back inputs SHALL be accepted every cycle; no backpressure.

Reset
REQ-029 While rst=1, out_valid, norm_sig, norm_exp, cout, overflow and zero SHALL all be 0, immediately and independent of clk.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight result; the first valid input after deassertion SHALL produce out_valid one cycle later.

Verification
REQ-031 Reset: assert rst between clock edges -> all outputs 0 immediately.
REQ-032 Align/add: sig_shift=0x800000, shift_amt=1, sig_fixed=0x800000, exp_in=127 -> next cycle norm_sig=0xC00000, norm_exp=127, cout=0, out_valid=1.
REQ-033 Carry normalize: 0x800000 + 0x800000, shift_amt=0, exp_in=127 -> norm_sig=0x800000, norm_exp=128, cout=1.
REQ-034 Large shift: shift_amt=30, sig_shift=0xFFFFFF, sig_fixed=0x900000, exp_in=100 -> norm_sig=0x900000, norm_exp=100.
REQ-035 Left normalize: sig_fixed=0x000100, sig_shift=0, shift_amt=24, exp_in=127 -> norm_sig=0x800000, norm_exp=112; with exp_in=5 instead -> norm_exp=0, norm_sig=0x001000.
REQ-036 Overflow/zero: 0xFFFFFF + 0xFFFFFF, shift_amt=0, exp_in=254 -> overflow=1, norm_exp=255, norm_sig=0; all-zero operands -> zero=1, norm_exp=0.
